// File: rtl/ldpc_parity_encoder_if.sv
// Serial info-bit input and parity-bit output streams of the LDPC parity encoder.
// The encoder uses the slave view; the upstream/downstream environment uses master.
interface ldpc_parity_encoder_if;
    logic s_valid;
    logic s_ready;
    logic s_data;
    logic m_valid;
    logic m_ready;
    logic m_data;
    logic m_last;

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_last
    );

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );
endinterface

// File: rtl/ldpc_parity_encoder.sv
// Serial LDPC parity encoder: circulant rows from an external G-ROM are XORed into a Z-bit parity register.
// Define PARITY_ACCUM_EN for IRA (running-XOR) parity output; default emits parity bits directly.
module ldpc_parity_encoder #(
    parameter int Z      = 360,
    parameter int GROUPS = 12,
    parameter int AW     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    ldpc_parity_encoder_if.slave bus,
    output logic [AW-1:0]        rom_addr,
    input  logic [Z-1:0]         rom_data,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int CW = (Z > 1) ? $clog2(Z) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(Z - 1);
    localparam logic [AW-1:0] LAST_GRP = AW'(GROUPS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, ACCUM, DRAIN} state_t;

    state_t          state, state_nxt;
    logic [Z-1:0]    parity;
    logic [Z-1:0]    row;
    logic [CW-1:0]   bit_cnt;
    logic [CW-1:0]   out_idx;
    logic [AW-1:0]   grp;
    logic            s_fire;
    logic            m_fire;
    logic            grp_end;
    logic            last_info;
    logic            last_out;
    logic            par_bit;

    // Handshakes decoded from state directly so the ready/valid outputs never feed back.
    assign s_fire    = bus.s_valid && (state == ACCUM);
    assign m_fire    = bus.m_ready && (state == DRAIN);
    assign grp_end   = (grp == LAST_GRP);
    assign last_info = grp_end && (bit_cnt == LAST_BIT);
    assign last_out  = (out_idx == LAST_BIT);
    assign par_bit   = parity[out_idx];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        bus.s_ready = 1'b0;
        bus.m_valid = 1'b0;
        bus.m_last  = 1'b0;
        rom_addr    = '0;
        busy        = 1'b1;
        frame_done  = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (bus.s_valid) state_nxt = LOAD;
            end
            LOAD: state_nxt = ACCUM;
            ACCUM: begin
                bus.s_ready = 1'b1;
                // Prefetch the next group's row so it is ready at the boundary.
                rom_addr    = grp_end ? '0 : grp + AW'(1);
                if (s_fire && last_info) state_nxt = DRAIN;
            end
            DRAIN: begin
                bus.m_valid = 1'b1;
                bus.m_last  = last_out;
                if (m_fire && last_out) begin
                    frame_done = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            parity  <= '0;
            row     <= '0;
            bit_cnt <= '0;
            grp     <= '0;
            out_idx <= '0;
        end else begin
            case (state)
                LOAD: begin
                    row     <= rom_data;
                    bit_cnt <= '0;
                    grp     <= '0;
                end
                ACCUM: begin
                    if (s_fire) begin
                        if (bus.s_data) parity <= parity ^ row;
                        if (bit_cnt != LAST_BIT) begin
                            row     <= {row[0], row[Z-1:1]};
                            bit_cnt <= bit_cnt + CW'(1);
                        end else begin
                            row     <= rom_data;
                            bit_cnt <= '0;
                            if (!grp_end) grp <= grp + AW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (m_fire) begin
                        if (last_out) begin
                            parity  <= '0;
                            out_idx <= '0;
                        end else begin
                            out_idx <= out_idx + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PARITY_ACCUM_EN
    logic run;

    // Running XOR of already-emitted parity bits; restarts at the top of every drain.
    always_ff @(posedge clk) begin
        if (rst)                      run <= 1'b0;
        else if (s_fire && last_info) run <= 1'b0;
        else if (m_fire)              run <= last_out ? 1'b0 : (run ^ par_bit);
    end

    assign bus.m_data = run ^ par_bit;
`else
    assign bus.m_data = par_bit;
`endif

endmodule

// File: tb/tb_ldpc_parity_encoder.sv
// Directed bench for ldpc_parity_encoder at Z=8, GROUPS=2 with ROM rows 8'h01 / 8'h03.
module tb_ldpc_parity_encoder;
    localparam int Z = 8;
    localparam int GROUPS = 2;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] rom_addr;
    logic [Z-1:0]  rom_data = '0;
    logic          busy;
    logic          frame_done;
    int            total = 0;
    int            bad = 0;

    ldpc_parity_encoder_if bus ();

    ldpc_parity_encoder #(.Z(Z), .GROUPS(GROUPS), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // G-ROM with 1-cycle registered read.
    always @(posedge clk) begin
        case (rom_addr)
            4'd0:    rom_data <= 8'h01;
            4'd1:    rom_data <= 8'h03;
            default: rom_data <= 8'h00;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_out(input logic [7:0] p);
        logic [7:0] r;
`ifdef PARITY_ACCUM_EN
        logic a;
        a = 1'b0;
        for (int j = 0; j < 8; j++) begin
            a = a ^ p[j];
            r[j] = a;
        end
`else
        r = p;
`endif
        return r;
    endfunction

    // Called at a negedge; returns at the negedge following the accepting posedge.
    task automatic send_bit(input logic b);
        int n;
        n = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        while (!bus.s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.s_ready) chk("s_ready_timeout", 32'(bus.s_ready), 32'd1);
        @(negedge clk);
    endtask

    task automatic send_bits(input logic [15:0] f, input int cnt);
        for (int i = 0; i < cnt; i++) send_bit(f[i]);
        bus.s_valid = 1'b0;
        bus.s_data  = 1'b0;
    endtask

    task automatic recv_frame(input string tag, input logic [7:0] p, input bit toggle);
        logic [7:0] eo;
        logic [7:0] got;
        logic [7:0] lastv;
        int k;
        int fd;
        int cyc;
        bit sr_bad;
        eo = exp_out(p);
        got = '0;
        lastv = '0;
        k = 0;
        fd = 0;
        cyc = 0;
        sr_bad = 0;
        chk({tag, "_mvalid_rise"}, 32'(bus.m_valid), 32'd1);
        while (k < 8 && cyc < 100) begin
            bus.m_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            #1;
            fd += int'(frame_done);
            if (bus.s_ready) sr_bad = 1;
            if (bus.m_valid && bus.m_ready) begin
                got[k]   = bus.m_data;
                lastv[k] = bus.m_last;
                k++;
            end else if (bus.m_valid) begin
                chk({tag, "_hold_data"}, 32'(bus.m_data), 32'(eo[k]));
                chk({tag, "_hold_last"}, 32'(bus.m_last), 32'(k == 7));
            end
            @(negedge clk);
            cyc++;
        end
        bus.m_ready = 1'b0;
        #1;
        fd += int'(frame_done);
        chk({tag, "_count"}, 32'(k), 32'd8);
        chk({tag, "_data"}, 32'(got), 32'(eo));
        chk({tag, "_last"}, 32'(lastv), 32'h80);
        chk({tag, "_done_pulses"}, 32'(fd), 32'd1);
        chk({tag, "_sready_low"}, 32'(sr_bad), 32'd0);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_idle_mvalid"}, 32'(bus.m_valid), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = 1'b0;
        bus.m_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sready", 32'(bus.s_ready), 32'd0);
        chk("rst_mvalid", 32'(bus.m_valid), 32'd0);
        chk("rst_mlast", 32'(bus.m_last), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: all-zero frame; also check prefetch address during group 0
        send_bit(1'b0);
        chk("t1_rom_addr_g0", 32'(rom_addr), 32'd1);
        send_bits(16'h0000, 15);
        recv_frame("t1", 8'h00, 1'b0);

        // 2: only info bit 0
        send_bits(16'h0001, 16);
        recv_frame("t2", 8'h01, 1'b0);

        // 3: only info bit 1 sees the row rotated once
        send_bits(16'h0002, 16);
        recv_frame("t3", 8'h80, 1'b0);

        // 4: only info bit 8 sees group-1 row
        send_bits(16'h0100, 16);
        recv_frame("t4", 8'h03, 1'b0);

        // 5: bits 0 and 9 with m_ready toggling: 01 ^ 81 = 80
        send_bits(16'h0201, 16);
        recv_frame("t5", 8'h80, 1'b1);

        // all ones: group 0 rotations XOR to FF, group 1 rotations cancel
        send_bits(16'hFFFF, 16);
        recv_frame("t_ones", 8'hFF, 1'b0);

        // 6: reset after 5 info bits, then a clean zero frame
        send_bits(16'h001F, 5);
        chk("t6_busy_mid", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_sready", 32'(bus.s_ready), 32'd0);
        chk("t6_mvalid", 32'(bus.m_valid), 32'd0);
        chk("t6_rom_addr", 32'(rom_addr), 32'd0);
        chk("t6_done", 32'(frame_done), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        send_bits(16'h0000, 16);
        recv_frame("t6_zero", 8'h00, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
